// File: rtl/sseg_pkg.sv
// Shared encodings for the score display: segment patterns, FSM states, anode scan table.
// No logic of its own; latency and backpressure are defined by the users of this package.
// Pure constants plus a combinational BCD-digit decoder.
package sseg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CONV   = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    localparam int BCD_ITER = 7;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Indexed by scan position: 0 = left tens (an[3]) ... 3 = right units (an[0]).
    localparam logic [3:0][3:0] ANODE_ONEHOT = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble: 7-bit binary (<=99) to two BCD digits.
// Latency: start_i loads on one edge, then 7 shift/add-3 edges; done_o marks the final one.
// No backpressure: a new start_i simply restarts the conversion.
module bin_to_bcd
    import sseg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [6:0] bin_i,
    output logic       done_o,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    // {tens, units, binary} working register shifted left as a whole.
    logic [14:0] sr_q, sr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [14:0] sr_adj;

    always_comb begin
        sr_adj = sr_q;
        if (sr_adj[10:7] >= 4'd5) sr_adj[10:7] = sr_adj[10:7] + 4'd3;
        if (sr_adj[14:11] >= 4'd5) sr_adj[14:11] = sr_adj[14:11] + 4'd3;

        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (start_i) begin
            sr_d  = {8'd0, bin_i};
            cnt_d = 3'(BCD_ITER);
        end else if (cnt_q != 3'd0) begin
            sr_d  = {sr_adj[13:0], 1'b0};
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // High during the cycle whose closing edge writes the final digits.
    assign done_o  = (cnt_q == 3'd1);
    assign tens_o  = sr_q[14:11];
    assign units_o = sr_q[10:7];

endmodule

// File: rtl/score_sseg_drv.sv
// Two-score BCD conversion and 4-digit multiplexed common-anode 7-segment drive.
// Latency: score_valid at edge t -> busy for 9 cycles, display regs written at edge t+9.
// Requests while busy are not stalled: the latest one is kept and converted next.
// LEADING_ZERO_BLANK_EN: blank a zero tens digit instead of showing '0'.
module score_sseg_drv
    import sseg_pkg::*;
#(
    parameter int CLK_HZ     = 65_000_000,
    parameter int REFRESH_HZ = 1_000,
    parameter int SCORE_MAX  = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] score_l,
    input  logic [6:0] score_r,
    input  logic       score_valid,
    output logic       busy,
    output logic [6:0] sseg_ca,
    output logic [3:0] sseg_an
);

    localparam int PERIOD = CLK_HZ / REFRESH_HZ;
    localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    state_e      state_q, state_d;
    logic [6:0]  shadow_l_q, shadow_l_d;
    logic [6:0]  shadow_r_q, shadow_r_d;
    logic        pending_q, pending_d;
    logic        commit;
    logic        start;

    logic [3:0]  disp_lt_q, disp_lu_q, disp_rt_q, disp_ru_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  ca_q, ca_d;
    logic        wrap;
    logic [3:0]  digit;
    logic [6:0]  seg;

    logic       l_done, r_done;
    logic [3:0] l_tens, l_units, r_tens, r_units;
    logic [6:0] clamp_l, clamp_r;

    assign clamp_l = (32'(shadow_l_q) > SCORE_MAX) ? 7'(SCORE_MAX) : shadow_l_q;
    assign clamp_r = (32'(shadow_r_q) > SCORE_MAX) ? 7'(SCORE_MAX) : shadow_r_q;
    assign start   = (state_q == ST_LOAD);

    bin_to_bcd u_bcd_l (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .bin_i   (clamp_l),
        .done_o  (l_done),
        .tens_o  (l_tens),
        .units_o (l_units)
    );

    bin_to_bcd u_bcd_r (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .bin_i   (clamp_r),
        .done_o  (r_done),
        .tens_o  (r_tens),
        .units_o (r_units)
    );

    always_comb begin
        state_d    = state_q;
        shadow_l_d = shadow_l_q;
        shadow_r_d = shadow_r_q;
        pending_d  = pending_q;
        commit     = 1'b0;

        if (score_valid) begin
            shadow_l_d = score_l;
            shadow_r_d = score_r;
            if (state_q != ST_IDLE) pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE:   if (score_valid) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_CONV;
            ST_CONV:   if (l_done && r_done) state_d = ST_COMMIT;
            ST_COMMIT: begin
                commit = 1'b1;
                // A request that arrived during this run restarts immediately.
                if (pending_q || score_valid) begin
                    state_d   = ST_LOAD;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shadow_l_q <= '0;
            shadow_r_q <= '0;
            pending_q  <= 1'b0;
            disp_lt_q  <= '0;
            disp_lu_q  <= '0;
            disp_rt_q  <= '0;
            disp_ru_q  <= '0;
        end else begin
            state_q    <= state_d;
            shadow_l_q <= shadow_l_d;
            shadow_r_q <= shadow_r_d;
            pending_q  <= pending_d;
            if (commit) begin
                disp_lt_q <= l_tens;
                disp_lu_q <= l_units;
                disp_rt_q <= r_tens;
                disp_ru_q <= r_units;
            end
        end
    end

    assign wrap = (presc_q == PW'(PERIOD - 1));

    always_comb begin
        case (idx_q)
            2'd0:    digit = disp_lt_q;
            2'd1:    digit = disp_lu_q;
            2'd2:    digit = disp_rt_q;
            default: digit = disp_ru_q;
        endcase
        seg = seg_decode(digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (!idx_q[0] && digit == 4'd0) seg = SEG_BLANK;
`endif
    end

    // Anode and cathodes load together on the wrap edge so no digit ever shows another's pattern.
    always_comb begin
        presc_d = wrap ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        an_d    = an_q;
        ca_d    = ca_q;
        if (wrap) begin
            idx_d = idx_q + 2'd1;
            an_d  = ANODE_ONEHOT[idx_q];
            ca_d  = seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= 4'b1111;
            ca_q    <= SEG_BLANK;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            ca_q    <= ca_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign sseg_an = an_q;
    assign sseg_ca = ca_q;

endmodule
